// File: rtl/flush_pkg.sv
// Shared types and helpers for the front-end flush/stall controller.
package flush_pkg;

  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int MAX_STAGES = 32;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  // Thermometer mask: bits [depth-1:0] set, youngest stage first.
  function automatic logic [MAX_STAGES-1:0] therm(input int unsigned depth);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (i < depth) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/flush_mask_gen.sv
// Per-event flush mask: each redirect kills its configured number of front-end stages.
// Combinational; simultaneous events OR together, so the deepest mask wins.
module flush_mask_gen
  import flush_pkg::*;
#(
  parameter int N_STAGES  = 2,
  parameter int JMP_DEPTH = 1,
  parameter int BR_DEPTH  = 2,
  parameter int JR_DEPTH  = 2
) (
  input  logic                jump_i,
  input  logic                bne_i,
  input  logic                jr_i,
  output logic [N_STAGES-1:0] ev_mask_o
);

  localparam logic [MAX_STAGES-1:0] JMP_M = therm(JMP_DEPTH);
  localparam logic [MAX_STAGES-1:0] BR_M  = therm(BR_DEPTH);
  localparam logic [MAX_STAGES-1:0] JR_M  = therm(JR_DEPTH);

  assign ev_mask_o = ({N_STAGES{jump_i}} & JMP_M[N_STAGES-1:0])
                   | ({N_STAGES{bne_i}}  & BR_M[N_STAGES-1:0])
                   | ({N_STAGES{jr_i}}   & JR_M[N_STAGES-1:0]);

endmodule

// File: rtl/flush_hazard_ctrl.sv
// Front-end flush/stall controller: redirects and load-use stalls become stage flushes,
// an ID bubble and PC/IF-IF/ID write enables, with optional multi-cycle flush hold.
module flush_hazard_ctrl
  import flush_pkg::*;
#(
  parameter int CTRL_W    = 10,
  parameter int N_STAGES  = 2,
  parameter int JMP_DEPTH = 1,
  parameter int BR_DEPTH  = 2,
  parameter int JR_DEPTH  = 2,
  parameter int EXTRA_CYC = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump,
  input  logic              bne,
  input  logic              jr,
  input  logic              stall,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [N_STAGES-1:0] flush_vec,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              busy,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int HC_W = (EXTRA_CYC > 0) ? $clog2(EXTRA_CYC + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LEN = HC_W'(EXTRA_CYC);

  state_e              state_q, state_d;
  logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_STAGES-1:0] hold_mask_q, hold_mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_STAGES-1:0] ev_mask;
  logic                redirect;
  logic                kill_id;

  flush_mask_gen #(
    .N_STAGES  (N_STAGES),
    .JMP_DEPTH (JMP_DEPTH),
    .BR_DEPTH  (BR_DEPTH),
    .JR_DEPTH  (JR_DEPTH)
  ) u_mask (
    .jump_i    (jump),
    .bne_i     (bne),
    .jr_i      (jr),
    .ev_mask_o (ev_mask)
  );

  assign redirect = jump | bne | jr;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    hold_mask_d = hold_mask_q;
    case (state_q)
      IDLE: begin
        if (redirect && (EXTRA_CYC > 0)) begin
          state_d     = HOLD;
          hold_mask_d = ev_mask;
          hold_cnt_d  = HOLD_LEN;
        end
      end
      HOLD: begin
        // A new redirect restarts the window and widens the held mask.
        if (redirect) begin
          hold_mask_d = hold_mask_q | ev_mask;
          hold_cnt_d  = HOLD_LEN;
        end else if (hold_cnt_q == HC_W'(1)) begin
          state_d     = IDLE;
          hold_mask_d = '0;
          hold_cnt_d  = '0;
        end else begin
          hold_cnt_d  = hold_cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign cnt_d = (redirect && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      hold_mask_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_mask_q <= hold_mask_d;
      cnt_q       <= cnt_d;
    end
  end

  assign flush_vec   = reset ? {N_STAGES{1'b1}}
                             : (ev_mask | ((state_q == HOLD) ? hold_mask_q : '0));
  assign kill_id     = flush_vec[STG_ID] | stall;
  assign ctrl_out    = kill_id ? '0 : ctrl_in;
  // The redirect target must still load into the PC when a stall coincides.
  assign pc_write    = reset | ~(stall & ~redirect);
  assign ifid_write  = pc_write;
  assign busy        = ~reset & (state_q == HOLD);
  assign flush_count = cnt_q;

endmodule

// File: tb/tb_flush_hazard_ctrl.sv
// Bench: three configurations (legacy, 2-cycle hold, 4-bit counter) share one stimulus stream.
module tb_flush_hazard_ctrl;

  localparam int JD = 1;
  localparam int BD = 2;
  localparam int RD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, jump, bne, jr, stall;
  logic [9:0] ctrl_in;

  logic [2:0][1:0] fv;
  logic [2:0][9:0] co;
  logic [2:0]      pw, iw, bz;
  logic [15:0]     cnt_a, cnt_b;
  logic [3:0]      cnt_c;

  flush_hazard_ctrl #(.CTRL_W(10), .N_STAGES(2), .JMP_DEPTH(JD), .BR_DEPTH(BD), .JR_DEPTH(RD),
                      .EXTRA_CYC(0), .CNT_W(16)) u_leg (
    .clk(clk), .reset(rst), .jump(jump), .bne(bne), .jr(jr), .stall(stall), .ctrl_in(ctrl_in),
    .ctrl_out(co[0]), .flush_vec(fv[0]), .pc_write(pw[0]), .ifid_write(iw[0]), .busy(bz[0]),
    .flush_count(cnt_a));

  flush_hazard_ctrl #(.CTRL_W(10), .N_STAGES(2), .JMP_DEPTH(JD), .BR_DEPTH(BD), .JR_DEPTH(RD),
                      .EXTRA_CYC(2), .CNT_W(16)) u_hold (
    .clk(clk), .reset(rst), .jump(jump), .bne(bne), .jr(jr), .stall(stall), .ctrl_in(ctrl_in),
    .ctrl_out(co[1]), .flush_vec(fv[1]), .pc_write(pw[1]), .ifid_write(iw[1]), .busy(bz[1]),
    .flush_count(cnt_b));

  flush_hazard_ctrl #(.CTRL_W(10), .N_STAGES(2), .JMP_DEPTH(JD), .BR_DEPTH(BD), .JR_DEPTH(RD),
                      .EXTRA_CYC(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst), .jump(jump), .bne(bne), .jr(jr), .stall(stall), .ctrl_in(ctrl_in),
    .ctrl_out(co[2]), .flush_vec(fv[2]), .pc_write(pw[2]), .ifid_write(iw[2]), .busy(bz[2]),
    .flush_count(cnt_c));

  int total = 0;
  int bad   = 0;

  // Reference model: hold is a time window after the latest redirect, mask is the union
  // of event masks over the chain of redirects that kept the window open.
  int         extra    [3] = '{0, 2, 2};
  int         cmax     [3] = '{65535, 65535, 15};
  int         last_red [3] = '{-1000, -1000, -1000};
  logic [1:0] acc      [3] = '{2'b00, 2'b00, 2'b00};
  int         mcnt     [3] = '{0, 0, 0};
  int         cyc = 0;

  logic [1:0] e_fv  [3];
  logic [9:0] e_co  [3];
  logic       e_pw  [3];
  logic       e_bz  [3];
  int         e_cnt [3];

  function automatic int obs_cnt(input int i);
    if (i == 0) return int'(cnt_a);
    if (i == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  task automatic drive(input logic r, input logic j, input logic b, input logic jv,
                       input logic s, input logic [9:0] c);
    int depth;
    logic [1:0] ev;
    bit red, hold;
    @(negedge clk);
    rst = r; jump = j; bne = b; jr = jv; stall = s; ctrl_in = c;
    #1;
    depth = 0;
    if (j  && JD > depth) depth = JD;
    if (b  && BD > depth) depth = BD;
    if (jv && RD > depth) depth = RD;
    ev  = 2'((1 << depth) - 1);
    red = j | b | jv;
    for (int i = 0; i < 3; i++) begin
      hold = (extra[i] > 0) && (cyc - last_red[i] >= 1) && (cyc - last_red[i] <= extra[i]);
      if (r) begin
        e_fv[i] = 2'b11; e_co[i] = '0; e_pw[i] = 1'b1; e_bz[i] = 1'b0;
      end else begin
        e_fv[i] = ev | (hold ? acc[i] : 2'b00);
        e_co[i] = (e_fv[i][1] | s) ? 10'h000 : c;
        e_pw[i] = !(s && !red);
        e_bz[i] = hold;
      end
      e_cnt[i] = mcnt[i];
      if (r) begin
        last_red[i] = -1000; acc[i] = 2'b00; mcnt[i] = 0;
      end else if (red) begin
        acc[i] = hold ? (acc[i] | ev) : ev;
        last_red[i] = cyc;
        if (mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h2AA);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
    total++; if (fv[0] !== 2'b11) begin bad++; $display("FAIL rst_fv got=%b want=11", fv[0]); end
    total++; if (co[0] !== 10'h000) begin bad++; $display("FAIL rst_ctrl got=%h want=000", co[0]); end
    total++; if (pw[0] !== 1'b1 || iw[0] !== 1'b1) begin bad++; $display("FAIL rst_we got=%b%b want=11", pw[0], iw[0]); end
    total++; if (bz[1] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bz[1]); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF);
    total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", cnt_a); end
    total++; if (fv[0] !== 2'b00 || co[0] !== 10'h3FF) begin bad++; $display("FAIL post_rst got fv=%b ctrl=%h want fv=00 ctrl=3ff", fv[0], co[0]); end
    total++; if (bz[1] !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", bz[1]); end
  endtask

  task automatic test_legacy;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
    total++; if (fv[0] !== 2'b01) begin bad++; $display("FAIL leg_jump_fv got=%b want=01", fv[0]); end
    total++; if (co[0] !== 10'h3FF) begin bad++; $display("FAIL leg_jump_ctrl got=%h want=3ff", co[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL leg_jump_busy got=%b want=0", bz[0]); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF);
    total++; if (fv[0] !== 2'b11 || co[0] !== 10'h000) begin bad++; $display("FAIL leg_bne got fv=%b ctrl=%h want fv=11 ctrl=000", fv[0], co[0]); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF);
    total++; if (fv[0] !== 2'b11 || co[0] !== 10'h000) begin bad++; $display("FAIL leg_jr got fv=%b ctrl=%h want fv=11 ctrl=000", fv[0], co[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL leg_busy got=%b want=0", bz[0]); end
    idle(3);
  endtask

  task automatic test_stall;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h155);
    total++; if (co[0] !== 10'h000) begin bad++; $display("FAIL stall_ctrl got=%h want=000", co[0]); end
    total++; if (pw[0] !== 1'b0 || iw[0] !== 1'b0) begin bad++; $display("FAIL stall_we got=%b%b want=00", pw[0], iw[0]); end
    total++; if (fv[0] !== 2'b00) begin bad++; $display("FAIL stall_fv got=%b want=00", fv[0]); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h155);
    total++; if (pw[0] !== 1'b1 || iw[0] !== 1'b1) begin bad++; $display("FAIL stall_bne_we got=%b%b want=11", pw[0], iw[0]); end
    total++; if (fv[0] !== 2'b11) begin bad++; $display("FAIL stall_bne_fv got=%b want=11", fv[0]); end
    idle(3);
  endtask

  task automatic test_hold;
    logic [1:0] want_fv [4] = '{2'b11, 2'b11, 2'b11, 2'b00};
    logic       want_bz [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, (k == 0), 1'b0, 1'b0, 10'h0F0);
      total++; if (fv[1] !== want_fv[k]) begin bad++; $display("FAIL hold_fv c%0d got=%b want=%b", k, fv[1], want_fv[k]); end
      total++; if (bz[1] !== want_bz[k]) begin bad++; $display("FAIL hold_busy c%0d got=%b want=%b", k, bz[1], want_bz[k]); end
    end
    idle(2);
  endtask

  task automatic test_restart;
    logic [1:0] want_fv [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
    logic       want_bz [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, (k == 0), 1'b0, (k == 1), 1'b0, 10'h0F0);
      total++; if (fv[1] !== want_fv[k]) begin bad++; $display("FAIL restart_fv c%0d got=%b want=%b", k, fv[1], want_fv[k]); end
      total++; if (bz[1] !== want_bz[k]) begin bad++; $display("FAIL restart_busy c%0d got=%b want=%b", k, bz[1], want_bz[k]); end
    end
    idle(2);
  endtask

  task automatic test_saturation;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
      total++; if (cnt_c !== 4'((k > 15) ? 15 : k)) begin bad++; $display("FAIL sat_cnt k%0d got=%0d want=%0d", k, cnt_c, (k > 15) ? 15 : k); end
    end
    idle(1);
    total++; if (cnt_c !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", cnt_c); end
    total++; if (cnt_a !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0d want=20", cnt_a); end
    idle(2);
  endtask

  task automatic test_reset_mid_hold;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3C3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C3);
    total++; if (fv[1] !== 2'b11 || co[1] !== 10'h000) begin bad++; $display("FAIL midrst got fv=%b ctrl=%h want fv=11 ctrl=000", fv[1], co[1]); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C3);
    total++; if (bz[1] !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bz[1]); end
    total++; if (cnt_b !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt_b); end
    total++; if (fv[1] !== 2'b00) begin bad++; $display("FAIL midrst_fv got=%b want=00", fv[1]); end
  endtask

  task automatic test_random;
    logic [14:0] obs, want;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), 10'($urandom));
      for (int i = 0; i < 3; i++) begin
        obs  = {fv[i], co[i], pw[i], iw[i], bz[i]};
        want = {e_fv[i], e_co[i], e_pw[i], e_pw[i], e_bz[i]};
        total++; if (obs !== want) begin bad++; $display("FAIL rand_out dut%0d cyc%0d got=%h want=%h", i, n, obs, want); end
        total++; if (obs_cnt(i) != e_cnt[i]) begin bad++; $display("FAIL rand_cnt dut%0d cyc%0d got=%0d want=%0d", i, n, obs_cnt(i), e_cnt[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; jump = 1'b0; bne = 1'b0; jr = 1'b0; stall = 1'b0; ctrl_in = '0;
    test_reset();
    test_legacy();
    test_stall();
    test_hold();
    test_restart();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flush_hazard_ctrl.md
Name: flush_hazard_ctrl

Overview:
- Parametrised front-end flush/stall controller for the 5-stage MIPS pipeline; the successor to the fixed IF/ID flush logic.
- Converts redirect events (jump, bne-taken, jr) and load-use stalls into:
  - a per-stage flush vector;
  - a bubbled ID control bus;
  - PC and IF/ID write enables.
- Adds an optional multi-cycle flush hold for longer fetch latency, plus a saturating flush-event counter.
- Sits between the hazard detection unit, the control unit and the IF/ID and ID/EX pipeline registers.

Parameters:
- CTRL_W, 10, width of ID control bus (RegDst..JRControl, ALUOp).
- N_STAGES, 2, number of flushable front-end stages; bit 0 = IF, bit 1 = ID; must be >= 2.
- JMP_DEPTH, 1, stages flushed by jump (1..N_STAGES).
- BR_DEPTH, 2, stages flushed by bne-taken (1..N_STAGES).
- JR_DEPTH, 2, stages flushed by jr (1..N_STAGES).
- EXTRA_CYC, 0, cycles the flush mask is held after the event cycle; 0 = single-cycle (legacy behaviour).
- CNT_W, 16, width of flush event counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- jump  in  1  jump resolved this cycle.
- bne  in  1  bne resolved taken this cycle.
- jr  in  1  jr resolved this cycle.
- stall  in  1  load-use stall request from hazard unit.
- ctrl_in  in  CTRL_W  raw ID control bus from control unit.
- ctrl_out  out  CTRL_W  control bus to ID/EX (zeroed on bubble).
- flush_vec  out  N_STAGES  per-stage flush (bit k kills stage k register).
- pc_write  out  1  PC write enable.
- ifid_write  out  1  IF/ID write enable.
- busy  out  1  flush hold active.
- flush_count  out  CNT_W  saturating count of redirect-event cycles.

Behaviour:

Clock and reset:
- Single clock; reset is synchronous, active-high, sampled on rising clk.

Event mask (combinational):
- redirect = jump | bne | jr.
- ev_mask = therm(JMP_DEPTH)&jump | therm(BR_DEPTH)&bne | therm(JR_DEPTH)&jr, where therm(d) sets bits [d-1:0].
- Simultaneous events therefore yield the deepest mask.

State machine:
- States IDLE and HOLD; registers are state, hold_cnt (enough bits for EXTRA_CYC) and hold_mask (N_STAGES).
- IDLE with redirect and EXTRA_CYC > 0 -> HOLD: hold_mask <= ev_mask, hold_cnt <= EXTRA_CYC.
- HOLD with redirect (restart): hold_mask <= hold_mask | ev_mask, hold_cnt <= EXTRA_CYC.
- HOLD without redirect: hold_cnt decrements; when hold_cnt == 1 -> IDLE and hold_mask <= 0.
- EXTRA_CYC = 0: the FSM never leaves IDLE and busy stays 0.

Outputs (zero latency from inputs):
- flush_vec = ev_mask | (state == HOLD ? hold_mask : 0).
- kill_id = flush_vec[1] | stall; ctrl_out = kill_id ? 0 : ctrl_in.
- pc_write = ifid_write = ~(stall & ~redirect). A redirect overrides a stall: the PC must load the target.
- A stall during HOLD still freezes PC and IF/ID; hold_cnt keeps counting.
- busy = (state == HOLD).

Counter:
- flush_count increments by 1 on every non-reset cycle with redirect = 1.
- It saturates at all-ones and does not wrap.

Reset:
- Registers: state = IDLE, hold_cnt = 0, hold_mask = 0, flush_count = 0.
- While reset is high, outputs are forced: flush_vec = all-ones, ctrl_out = 0, pc_write = 1, ifid_write = 1, busy = 0.
- Events present during reset are ignored: no hold is loaded and nothing is counted.
- A reset arriving mid-HOLD aborts the hold; on the next cycle the block is in IDLE.

Decomposition:
- Package flush_pkg:
  - stage index constants STG_IF = 0, STG_ID = 1;
  - state enum {IDLE, HOLD};
  - therm-mask function.
- Sub-module flush_mask_gen (parameters N_STAGES and the three depths): computes ev_mask from jump/bne/jr.
- Top level holds the FSM, the counter and the output gating.

Test Plan:
All scenarios use CTRL_W = 10, N_STAGES = 2, JMP_DEPTH = 1, BR_DEPTH = 2, JR_DEPTH = 2, CNT_W = 16.
1. Legacy, EXTRA_CYC = 0:
   - jump pulse, ctrl_in = 0x3FF -> flush_vec = 01, ctrl_out = 0x3FF, busy = 0.
   - bne pulse -> flush_vec = 11, ctrl_out = 0x000.
   - jr pulse -> flush_vec = 11, ctrl_out = 0x000.
2. Stall only:
   - stall = 1, ctrl_in = 0x155 -> ctrl_out = 0, pc_write = 0, ifid_write = 0, flush_vec = 00.
   - stall = 1 with bne = 1 in the same cycle -> pc_write = 1, flush_vec = 11.
3. Hold, EXTRA_CYC = 2:
   - bne in cycle 0 -> flush_vec = 11 in cycles 0, 1, 2, then 00 in cycle 3.
   - busy = 1 in cycles 1 and 2.
4. Restart, EXTRA_CYC = 2:
   - jump in cycle 0 -> flush_vec = 01.
   - jr in cycle 1 -> flush_vec = 11 in cycles 1, 2, 3; busy falls in cycle 4.
5. Counter saturation, CNT_W = 4: 20 redirect cycles -> flush_count = 15 and stays at 15.
6. Reset mid-HOLD:
   - reset during cycle 1 of a 2-cycle hold -> flush_vec = 11, ctrl_out = 0 while reset is high.
   - Next cycle: busy = 0, flush_count = 0, flush_vec = 00.
